pwm_cfg_sequencer: RTL

PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

---
 rtl/pwm_regs_pkg.sv | 64 ++++++
 rtl/pwm_cfg_sequencer_if.sv | 14 +
 rtl/pwm_cfg_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pwm_regs_pkg.sv
// Shared PWM timer register map, sequencer state encoding and the
// step-to-write mapping used when programming one timer.
package pwm_regs_pkg;

  localparam logic [31:0] OFF_CTRL     = 32'h14;
  localparam logic [31:0] OFF_RELOAD   = 32'h04;
  localparam logic [31:0] OFF_PRESCALE = 32'h08;
  localparam logic [31:0] OFF_CFG      = 32'h18;
  localparam logic [31:0] OFF_CMPX     = 32'h0c;
  localparam logic [31:0] OFF_CMPY     = 32'h10;
  localparam logic [31:0] OFF_PWM0CFG  = 32'h1c;
  localparam logic [31:0] OFF_PWM1CFG  = 32'h20;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [3:0] LAST_STEP = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DONE,
    ST_ABORT
  } state_e;

  typedef struct packed {
    logic [31:0] reload;
    logic [31:0] prescale;
    logic [31:0] cmpx;
    logic [31:0] cmpy;
    logic [2:0]  cfg;
    logic [11:0] pwm0cfg;
    logic [11:0] pwm1cfg;
    logic [3:0]  ctrl;
  } vals_t;

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] dat;
  } wr_t;

  // The timer is disabled first and re-enabled last so it never runs on a
  // half-written configuration.
  function automatic wr_t step_map(input logic [3:0] step, input vals_t v);
    wr_t w;
    w.off = OFF_CTRL;
    w.dat = '0;
    case (step)
      4'd1: begin w.off = OFF_RELOAD;   w.dat = v.reload;             end
      4'd2: begin w.off = OFF_PRESCALE; w.dat = v.prescale;           end
      4'd3: begin w.off = OFF_CFG;      w.dat = {29'd0, v.cfg};       end
      4'd4: begin w.off = OFF_CMPX;     w.dat = v.cmpx;               end
      4'd5: begin w.off = OFF_CMPY;     w.dat = v.cmpy;               end
      4'd6: begin w.off = OFF_PWM0CFG;  w.dat = {20'd0, v.pwm0cfg};   end
      4'd7: begin w.off = OFF_PWM1CFG;  w.dat = {20'd0, v.pwm1cfg};   end
      4'd8: begin w.off = OFF_CTRL;     w.dat = {28'd0, v.ctrl};      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/pwm_cfg_sequencer_if.sv
// Wishbone classic write-only bus between the sequencer and the timer block.
interface pwm_cfg_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        ack;
  logic        err;

  modport master (output cyc, stb, we, adr, dat, sel, input ack, err);
  modport slave  (input cyc, stb, we, adr, dat, sel, output ack, err);
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Programs one PWM timer with a fixed nine-write Wishbone sequence from a
// snapshot of the value inputs, reporting done or abort with the failing step.
module pwm_cfg_sequencer
  import pwm_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] STRIDE    = 32'h0000_1000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start_i,
  input  logic [1:0]                 tsel_i,
  input  logic [31:0]                reload_i,
  input  logic [31:0]                prescale_i,
  input  logic [31:0]                cmpx_i,
  input  logic [31:0]                cmpy_i,
  input  logic [2:0]                 cfg_i,
  input  logic [11:0]                pwm0cfg_i,
  input  logic [11:0]                pwm1cfg_i,
  input  logic [3:0]                 ctrl_i,
  pwm_cfg_sequencer_if.master        m,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [3:0]                 err_step_o,
  output logic [1:0]                 err_code_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [3:0]  step_q, step_d;
  logic [15:0] tmo_q;
  logic [31:0] base_q, base_d;
  vals_t       snap_q, in_vals, src_d;
  wr_t         wr_d;
  logic        cyc_q, stb_q, we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q, dat_q;
  logic        busy_q, done_q, err_q;
  logic [3:0]  err_step_q;
  logic [1:0]  err_code_q;

  // In IDLE the next write is step 0 taken straight from the inputs; after
  // that every write comes from the snapshot.
  always_comb begin
    in_vals = '{reload: reload_i, prescale: prescale_i, cmpx: cmpx_i,
                cmpy: cmpy_i, cfg: cfg_i, pwm0cfg: pwm0cfg_i,
                pwm1cfg: pwm1cfg_i, ctrl: ctrl_i};
    step_d  = step_q + 4'd1;
    base_d  = base_q;
    src_d   = snap_q;
    if (state_q == ST_IDLE) begin
      step_d = 4'd0;
      base_d = BASE_ADDR + 32'(tsel_i) * STRIDE;
      src_d  = in_vals;
    end
    wr_d = step_map(step_d, src_d);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      tmo_q      <= '0;
      base_q     <= '0;
      snap_q     <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_REQ;
            snap_q     <= in_vals;
            base_q     <= base_d;
            step_q     <= step_d;
            tmo_q      <= '0;
            cyc_q      <= 1'b1;
            stb_q      <= 1'b1;
            we_q       <= 1'b1;
            sel_q      <= 4'hF;
            adr_q      <= base_d + wr_d.off;
            dat_q      <= wr_d.dat;
            busy_q     <= 1'b1;
            err_step_q <= '0;
            err_code_q <= ERR_NONE;
          end
        end
        ST_REQ: begin
          // err is tested before ack so a simultaneous ack never commits.
          if (m.err || (!m.ack && tmo_q == TMO_LAST)) begin
            state_q    <= ST_ABORT;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            err_q      <= 1'b1;
            err_step_q <= step_q;
            err_code_q <= m.err ? ERR_BUS : ERR_TIMEOUT;
          end else if (m.ack) begin
            state_q <= (step_q == LAST_STEP) ? ST_DONE : ST_GAP;
            done_q  <= (step_q == LAST_STEP);
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        ST_GAP: begin
          state_q <= ST_REQ;
          step_q  <= step_d;
          tmo_q   <= '0;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          sel_q   <= 4'hF;
          adr_q   <= base_q + wr_d.off;
          dat_q   <= wr_d.dat;
        end
        ST_DONE, ST_ABORT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m.cyc      = cyc_q;
  assign m.stb      = stb_q;
  assign m.we       = we_q;
  assign m.sel      = sel_q;
  assign m.adr      = adr_q;
  assign m.dat      = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_step_o = err_step_q;
  assign err_code_o = err_code_q;

endmodule
